demux_rr_scheduler: RTL and testbench

//  Sequences a shared 1-to-N demultiplexer: accepts words on a valid/ready input and steers each to one of N consumers.

---
 rtl/demux_sched_pkg.sv | 16 +
 rtl/rr_prio_find.sv | 31 +++
 rtl/demux_rr_scheduler.sv | 99 +++++++++
 tb/tb_demux_rr_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and helpers for the round-robin demux scheduler.
package demux_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int N_OUT_DEF  = 4;

  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/rr_prio_find.sv
// Rotating first-one finder: first set bit of i_req at or after i_start, wrapping.
// Only defined when DEMUX_SKIP_EN is set, since only the skip-ahead scheduler uses it.
`ifdef DEMUX_SKIP_EN
module rr_prio_find #(
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic [N_OUT-1:0] i_req,
  input  logic [SEL_W-1:0] i_start,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_found
);

  logic [SEL_W-1:0] w_k;

  // Walk from farthest to nearest so the nearest requester wins; index wraps because N_OUT is 2^SEL_W.
  always_comb begin
    o_idx   = i_start;
    o_found = 1'b0;
    w_k     = i_start;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      w_k = i_start + SEL_W'(i);
      if (i_req[w_k]) begin
        o_idx   = w_k;
        o_found = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/demux_rr_scheduler.sv
// Single-producer to N-consumer demux sequencer with one-word output register.
// Define DEMUX_SKIP_EN to let round-robin words skip ahead to the first ready channel.
module demux_rr_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_dest,
  input  logic              in_dest_vld,
  output logic [DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              busy
);

  state_t              r_state;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_rr_ptr;
  logic                r_is_rr;
  logic [DATA_W-1:0]   r_data;
  logic [N_OUT-1:0]    r_out_valid;

  logic                w_deliver;
  logic                w_in_ready;
  logic                w_accept;
  logic [SEL_W-1:0]    w_ptr_eff;
  logic [SEL_W-1:0]    w_rr_sel;
  logic [SEL_W-1:0]    w_tgt;

  assign w_deliver  = (r_state == HOLD) && out_ready[r_sel];
  assign w_in_ready = enable && ((r_state == IDLE) || w_deliver);
  assign w_accept   = in_valid && w_in_ready;

  // A round-robin word leaving this cycle moves the pointer before the next word picks its target,
  // which is what keeps back-to-back round-robin traffic rotating without a bubble.
  assign w_ptr_eff = (w_deliver && r_is_rr) ? SEL_W'(next_ptr(32'(r_sel), N_OUT)) : r_rr_ptr;

`ifdef DEMUX_SKIP_EN
  logic [SEL_W-1:0] w_find_idx;
  logic             w_find_ok;

  rr_prio_find #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_find (
    .i_req   (out_ready),
    .i_start (w_ptr_eff),
    .o_idx   (w_find_idx),
    .o_found (w_find_ok)
  );

  assign w_rr_sel = w_find_ok ? w_find_idx : w_ptr_eff;
`else
  assign w_rr_sel = w_ptr_eff;
`endif

  assign w_tgt = in_dest_vld ? in_dest : w_rr_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= '0;
      r_rr_ptr    <= '0;
      r_is_rr     <= 1'b0;
      r_data      <= '0;
      r_out_valid <= '0;
    end else begin
      r_rr_ptr <= w_ptr_eff;
      if (w_accept) begin
        r_state     <= HOLD;
        r_data      <= in_data;
        r_sel       <= w_tgt;
        r_is_rr     <= !in_dest_vld;
        r_out_valid <= N_OUT'(1) << w_tgt;
      end else if (w_deliver) begin
        r_state     <= IDLE;
        r_sel       <= '0;
        r_is_rr     <= 1'b0;
        r_out_valid <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_data;
  assign out_valid = r_out_valid;
  assign cur_sel   = r_sel;
  assign busy      = (r_state == HOLD);

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with a transfer-level reference model.
module tb_demux_rr_scheduler;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_dest;
  logic          in_dest_vld;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [SW-1:0] cur_sel;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  demux_rr_scheduler #(.DATA_W(DW), .N_OUT(N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_dest(in_dest), .in_dest_vld(in_dest_vld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .cur_sel(cur_sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one word in flight; a clock edge first lets the held word leave, then admits a new one.
  bit       m_started = 0;
  bit       m_held    = 0;
  int       m_data    = 0;
  int       m_sel     = 0;
  bit       m_rr      = 0;
  int       m_ptr     = 0;

  always @(posedge clk) begin : model
    bit held, rr, room, found;
    int sel, ptr, tgt;
    if (rst) begin
      m_started <= 1;
      m_held    <= 0;
      m_data    <= 0;
      m_sel     <= 0;
      m_rr      <= 0;
      m_ptr     <= 0;
    end else if (m_started) begin
      held = m_held; rr = m_rr; sel = m_sel; ptr = m_ptr;
      room = enable && (!held || out_ready[sel]);
      if (held && out_ready[sel]) begin
        if (rr) ptr = (sel + 1) % N;
        held = 0;
      end
      if (in_valid && room) begin
        tgt = ptr;
        if (in_dest_vld) tgt = int'(in_dest);
`ifdef DEMUX_SKIP_EN
        else begin
          found = 0;
          for (int s = 0; s < N; s++)
            if (!found && out_ready[(ptr + s) % N]) begin
              tgt = (ptr + s) % N;
              found = 1;
            end
        end
`endif
        held = 1; rr = !in_dest_vld; sel = tgt;
        m_data <= int'(in_data);
      end
      m_held <= held;
      m_rr   <= rr;
      m_sel  <= sel;
      m_ptr  <= ptr;
    end
  end

  always @(negedge clk) begin : compare
    if (m_started) begin
      check("model_valid", 32'(out_valid), m_held ? (32'd1 << m_sel) : 32'd0);
      check("model_busy", 32'(busy), 32'(m_held));
      check("model_sel", 32'(cur_sel), m_held ? 32'(m_sel) : 32'd0);
      check("model_ready", 32'(in_ready), 32'(enable && (!m_held || out_ready[m_sel])));
      if (m_held) check("model_data", 32'(out_data), 32'(m_data));
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  logic [N-1:0] exp_rr [5];

  initial begin : stim
    exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
    exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;
    rst = 1; enable = 0; in_valid = 1; in_data = 8'hEE; in_dest = 0; in_dest_vld = 0;
    out_ready = 4'b1111;

    // Reset with a pending input word
    to_drive(); to_drive();
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 32'h0);
    check("t1_ready", 32'(in_ready), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_sel", 32'(cur_sel), 32'h0);
    @(posedge clk); #1;
    rst = 0; enable = 1; in_valid = 1; in_data = 8'hA1; out_ready = 4'b1111;

    // Back-to-back round robin
    for (int i = 0; i < 5; i++) begin
      to_drive();
      if (i < 4) in_data = 8'hA2 + 8'(i);
      else in_valid = 0;
      @(negedge clk);
      check("t2_valid", 32'(out_valid), 32'(exp_rr[i]));
      check("t2_data", 32'(out_data), 32'hA1 + 32'(i));
      check("t2_ready", 32'(in_ready), 32'h1);
    end

    // Explicit destination stalled by its consumer
    to_drive();
    in_valid = 1; in_dest_vld = 1; in_dest = 2'd2; in_data = 8'h5C; out_ready = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      to_drive();
      if (c == 0) begin in_valid = 0; in_dest_vld = 0; end
      if (c == 3) out_ready = 4'b0100;
      @(negedge clk);
      check("t3_valid", 32'(out_valid), 32'h4);
      check("t3_data", 32'(out_data), 32'h5C);
      check("t3_ready", 32'(in_ready), (c == 3) ? 32'h1 : 32'h0);
    end

    // Enable dropped while holding on ch1 (pointer still 1 after the explicit word)
    to_drive();
    out_ready = 4'b0000; in_valid = 1; in_data = 8'h3D;
    @(negedge clk);
    check("t4_idle_valid", 32'(out_valid), 32'h0);
    to_drive();
    in_valid = 0; enable = 0;
    @(negedge clk);
    check("t4_valid", 32'(out_valid), 32'h2);
    check("t4_ready", 32'(in_ready), 32'h0);
    to_drive();
    out_ready = 4'b0010;
    @(negedge clk);
    check("t4_ready_dis", 32'(in_ready), 32'h0);
    to_drive();
    in_valid = 1; in_data = 8'h99;
    @(negedge clk);
    check("t4_drained", 32'(out_valid), 32'h0);
    check("t4_busy", 32'(busy), 32'h0);
    check("t4_ready_idle", 32'(in_ready), 32'h0);
    to_drive();
    @(negedge clk);
    check("t4_no_accept", 32'(busy), 32'h0);

    // Reset while holding on ch3
    to_drive();
    enable = 1; in_valid = 1; in_dest_vld = 1; in_dest = 2'd3; in_data = 8'h77; out_ready = 4'b0000;
    to_drive();
    in_valid = 0; in_dest_vld = 0;
    @(negedge clk);
    check("t5_hold", 32'(out_valid), 32'h8);
    to_drive();
    rst = 1;
    to_drive();
    rst = 0;
    @(negedge clk);
    check("t5_valid", 32'(out_valid), 32'h0);
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_data", 32'(out_data), 32'h0);
    to_drive();
    in_valid = 1; in_data = 8'h42;
    to_drive();
    in_valid = 0;
    @(negedge clk);
    check("t5_rr_ch0", 32'(out_valid), 32'h1);

    // ch0 delivers (pointer -> 1) while a round-robin word arrives with ch1 not ready
    to_drive();
    out_ready = 4'b1001; in_valid = 1; in_data = 8'h66;
    to_drive();
    in_data = 8'h67;
`ifdef DEMUX_SKIP_EN
    @(negedge clk);
    check("t6_skip", 32'(out_valid), 32'h8);
    to_drive();
    in_valid = 0;
    @(negedge clk);
    check("t6_next", 32'(out_valid), 32'h1);
`else
    out_ready = 4'b0010;
    @(negedge clk);
    check("t6_strict", 32'(out_valid), 32'h2);
    to_drive();
    in_valid = 0;
    @(negedge clk);
    check("t6_next", 32'(out_valid), 32'h4);
`endif
    check("t6_data", 32'(out_data), 32'h67);

    // Mixed traffic checked only by the model
    for (int k = 0; k < 80; k++) begin
      to_drive();
      in_valid    = 1'($urandom_range(0, 1));
      in_data     = 8'($urandom);
      in_dest_vld = ($urandom_range(0, 3) == 0);
      in_dest     = 2'($urandom);
      out_ready   = 4'($urandom);
      enable      = ($urandom_range(0, 7) != 0);
    end
    to_drive();
    in_valid = 0; out_ready = 4'b1111; enable = 1;
    to_drive(); to_drive();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
